riscv_muldiv_iter: RTL and testbench
====================================

# riscv_muldiv_iter

Iterative, parametrised-width RV M-extension execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits beside the single-cycle ALU in the execute stage and takes decoded operands through a valid/ready handshake. It returns one XLEN result per operation. Multiply and divide use a shared radix-2 datapath at one bit per cycle; divide special cases take a one-cycle fast path.

## Interface
- XLEN, 32, operand/result width; legal values are even and ≥ 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous abort of any in-flight op; highest priority after reset.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept; high exactly when state is IDLE.
- funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_i  in  XLEN  operand 1: multiplicand / dividend.
- rs2_i  in  XLEN  operand 2: multiplier / divisor.
- valid_o  out  1  result valid; high exactly when state is DONE.
- ready_i  in  1  consumer accepts the result.
- result_o  out  XLEN  result; registered and stable while valid_o is high.
- busy_o  out  1  high when state is CALC or DONE.

## Operation
- States are IDLE, CALC and DONE.
- **Reset:** state is IDLE. ready_o=1, valid_o=0, busy_o=0, result_o=0, and all internal registers are 0.
- **IDLE:**
  - On valid_i & ready_o, latch funct3 and the operand magnitudes, plus a result-negate flag.
  - Signed ops are MULH, DIV and REM. For these, take the absolute value of each negative operand.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MUL takes magnitudes as signed; its low half is sign-agnostic, so either treatment is fine.
- **Negate flag:**
  - For MUL, MULH, MULHSU and DIV: sign(rs1) XOR sign(rs2), where sign is 0 for operands treated as unsigned.
  - For REM: sign(rs1).
- **Fast path (IDLE → DONE directly):**
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow, rs1 = 1 followed by XLEN-1 zeros and rs2 = all ones: DIV → rs1; REM → 0.
- **Otherwise IDLE → CALC.** A counter loads XLEN-1.
- **CALC, multiply:**
  - Shift-add into a 2·XLEN accumulator: if the multiplier LSB is 1, add the multiplicand to the upper half.
  - Then shift the accumulator and multiplier right by 1.
- **CALC, divide:**
  - Restoring division: shift the remainder:quotient pair left by 1.
  - Trial-subtract the divisor from the remainder. If it is non-negative, commit the subtraction and set the quotient LSB.
- **CALC exit:** when the counter is 0 after the final step, go to DONE. Write result_o once on that transition:
  - MUL → low XLEN of the product.
  - MULH, MULHSU, MULHU → high XLEN of the product.
  - DIV/DIVU → quotient; REM/REMU → remainder.
  - Apply two's-complement negation when the negate flag is set. For multiply, negate the full 2·XLEN product before selecting the half.
- **DONE:** hold result_o. On ready_i go to IDLE. No new request is accepted in the same cycle.
- **flush_i:** in CALC or DONE, go to IDLE next edge and drop the result; valid_o falls next cycle. In IDLE, flush_i blocks acceptance that cycle.
- **Arithmetic rules:** all arithmetic is modulo 2^XLEN or 2^(2·XLEN) with no exceptions. Undefined funct3 cannot occur; all 8 codes are legal.

## Timing
- Accept edge is cycle 0.
- Normal op: CALC occupies cycles 1..XLEN; valid_o is first high in cycle XLEN+1. Latency is XLEN+1 cycles (33 at XLEN=32).
- Fast path: valid_o is high in cycle 1.
- Minimum issue interval: XLEN+3 cycles normal, 3 cycles fast path (accept, DONE with ready_i=1, IDLE).
- ready_o and valid_o are decoded from registered state only. There is no combinational path from valid_i or ready_i to any output.
- Reset mid-op: outputs return to reset values asynchronously, and the op is lost.
- While valid_o=1 and ready_i=0, result_o, valid_o and ready_o hold indefinitely.

## Test plan
- **Latency:** XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB; valid_o rises exactly 33 cycles after accept; ready_o low for cycles 1..33.
- **High-half multiplies:** rs1=rs2=0xFFFFFFFF.
  - MULHU → 0xFFFFFFFE
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
  - MUL → 0x00000001
- **Signed divide:** rs1=0xFFFFFFF9 (-7), rs2=2.
  - DIV → 0xFFFFFFFD
  - REM → 0xFFFFFFFF
  - DIVU 100/7 → 14; REMU 100/7 → 2
- **Fast path**, valid_o in cycle 1 for each:
  - DIVU 5/0 → 0xFFFFFFFF
  - REM 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM of the same operands → 0
- **Backpressure:** hold ready_i=0 for 5 cycles in DONE while pulsing valid_i with new operands. Required: result_o stable, no second accept, ready_o=0; IDLE on the first ready_i=1 edge.
- **Abort paths:**
  - flush_i in CALC cycle 10 → IDLE next cycle, no valid_o; the following MULHU 3×5 returns 0.
  - rst_n low in CALC cycle 4 → immediate ready_o=1, valid_o=0, result_o=0.

Source files
------------

// File: rtl/riscv_muldiv_iter.sv
// Iterative RV M-extension execute unit: radix-2 shift-add multiply and restoring divide
// at one bit per cycle, with a one-cycle fast path for divide-by-zero and signed overflow.
module riscv_muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          r_state;
    logic            r_ready;
    logic            r_valid;
    logic            r_busy;
    logic            r_neg;
    logic [2:0]      r_funct3;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_result;

    logic            w_is_div;
    logic            w_rs1_sgn;
    logic            w_rs2_sgn;
    logic            w_rs1_neg;
    logic            w_rs2_neg;
    logic            w_neg_in;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_rs1_mag;
    logic [XLEN-1:0] w_rs2_mag;
    logic [XLEN-1:0] w_a_init;
    logic [XLEN-1:0] w_b_init;
    logic [XLEN-1:0] w_fast_res;
    logic [XLEN-1:0] w_int_min;

    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_mul_hi;
    logic [XLEN-1:0]   w_mul_lo;
    logic [XLEN-1:0]   w_div_hi;
    logic [XLEN-1:0]   w_div_lo;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_final;

    // Request decode: operand magnitudes, negate flag and fast-path detection
    always_comb begin
        w_int_min  = {1'b1, {(XLEN-1){1'b0}}};
        w_is_div   = funct3_i[2];
        w_rs1_sgn  = (funct3_i != F_MULHU) && (funct3_i != F_DIVU) && (funct3_i != F_REMU);
        w_rs2_sgn  = w_rs1_sgn && (funct3_i != F_MULHSU);
        w_rs1_neg  = w_rs1_sgn & rs1_i[XLEN-1];
        w_rs2_neg  = w_rs2_sgn & rs2_i[XLEN-1];
        w_rs1_mag  = w_rs1_neg ? -rs1_i : rs1_i;
        w_rs2_mag  = w_rs2_neg ? -rs2_i : rs2_i;
        w_neg_in   = (funct3_i == F_REM) ? w_rs1_neg : (w_rs1_neg ^ w_rs2_neg);
        w_a_init   = w_is_div ? w_rs2_mag : w_rs1_mag;
        w_b_init   = w_is_div ? w_rs1_mag : w_rs2_mag;
        w_div_zero = w_is_div && (rs2_i == '0);
        w_ovf      = ((funct3_i == F_DIV) || (funct3_i == F_REM)) &&
                     (rs1_i == w_int_min) && (rs2_i == '1);
        w_fast     = w_div_zero | w_ovf;
        w_fast_res = '0;
        if (w_div_zero) begin
            w_fast_res = funct3_i[1] ? rs1_i : '1;
        end else if (w_ovf) begin
            w_fast_res = funct3_i[1] ? '0 : rs1_i;
        end
    end

    // One datapath step: shift-add for multiply, restoring trial-subtract for divide
    always_comb begin
        w_addend = r_b[0] ? r_a : '0;
        w_sum    = {1'b0, r_hi} + {1'b0, w_addend};
        w_mul_hi = w_sum[XLEN:1];
        w_mul_lo = {w_sum[0], r_b[XLEN-1:1]};
        w_shift  = {r_hi, r_b[XLEN-1]};
        w_trial  = w_shift - {1'b0, r_a};
        if (!w_trial[XLEN]) begin
            w_div_hi = w_trial[XLEN-1:0];
            w_div_lo = {r_b[XLEN-2:0], 1'b1};
        end else begin
            w_div_hi = w_shift[XLEN-1:0];
            w_div_lo = {r_b[XLEN-2:0], 1'b0};
        end
        w_hi_nxt = r_funct3[2] ? w_div_hi : w_mul_hi;
        w_lo_nxt = r_funct3[2] ? w_div_lo : w_mul_lo;
    end

    // Sign fix-up and result selection for the final CALC step
    always_comb begin
        w_prod   = {w_hi_nxt, w_lo_nxt};
        w_prod_s = r_neg ? -w_prod : w_prod;
        w_quo_s  = r_neg ? -w_lo_nxt : w_lo_nxt;
        w_rem_s  = r_neg ? -w_hi_nxt : w_hi_nxt;
        w_final  = '0;
        case (r_funct3)
            F_MUL:    w_final = w_prod_s[XLEN-1:0];
            F_MULH:   w_final = w_prod_s[2*XLEN-1:XLEN];
            F_MULHSU: w_final = w_prod_s[2*XLEN-1:XLEN];
            F_MULHU:  w_final = w_prod_s[2*XLEN-1:XLEN];
            F_DIV:    w_final = w_quo_s;
            F_DIVU:   w_final = w_quo_s;
            F_REM:    w_final = w_rem_s;
            F_REMU:   w_final = w_rem_s;
            default:  w_final = '0;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_neg    <= 1'b0;
            r_funct3 <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i && !flush_i) begin
                        r_funct3 <= funct3_i;
                        r_neg    <= w_neg_in;
                        r_a      <= w_a_init;
                        r_b      <= w_b_init;
                        r_hi     <= '0;
                        r_cnt    <= CW'(XLEN - 1);
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        r_state  <= S_IDLE;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_result <= '0;
                    end else begin
                        r_hi <= w_hi_nxt;
                        r_b  <= w_lo_nxt;
                        if (r_cnt == '0) begin
                            r_result <= w_final;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (flush_i || ready_i) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        if (flush_i) begin
                            r_result <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign valid_o  = r_valid;
    assign busy_o   = r_busy;
    assign result_o = r_result;

endmodule

// File: tb/tb_riscv_muldiv_iter.sv
// Directed bench for riscv_muldiv_iter: vector table of ops with expected result and
// latency, plus sequences for backpressure, flush and mid-op reset.
module tb_riscv_muldiv_iter;

    localparam int unsigned XLEN = 32;
    localparam int          LAT  = XLEN + 1;
    localparam int          NV   = 25;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef struct {
        logic [2:0]      f3;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vec [NV];

    riscv_muldiv_iter #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for valid_o, capture result, then hand it off.
    task automatic run_op(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          output logic [XLEN-1:0] res, output int lat, output int bad);
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        lat = 1;
        bad = 0;
        while (valid_o !== 1'b1 && lat < 4 * LAT) begin
            if (ready_o !== 1'b0 || busy_o !== 1'b1) bad++;
            tick();
            lat++;
        end
        if (ready_o !== 1'b0) bad++;
        res = result_o;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
    endtask

    logic [XLEN-1:0] res;
    int              lat;
    int              bad;
    int              seen;

    initial begin
        vec[0]  = '{F_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, LAT};
        vec[1]  = '{F_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, LAT};
        vec[2]  = '{F_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, LAT};
        vec[3]  = '{F_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, LAT};
        vec[4]  = '{F_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000001, LAT};
        vec[5]  = '{F_DIV,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, LAT};
        vec[6]  = '{F_REM,    32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, LAT};
        vec[7]  = '{F_DIVU,   32'd100,       32'd7,        32'd14,       LAT};
        vec[8]  = '{F_REMU,   32'd100,       32'd7,        32'd2,        LAT};
        vec[9]  = '{F_DIVU,   32'd5,         32'd0,        32'hFFFFFFFF, 1};
        vec[10] = '{F_REM,    32'd5,         32'd0,        32'd5,        1};
        vec[11] = '{F_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
        vec[12] = '{F_REM,    32'h80000000,  32'hFFFFFFFF, 32'h00000000, 1};
        vec[13] = '{F_MULH,   32'h80000000,  32'h80000000, 32'h40000000, LAT};
        vec[14] = '{F_DIV,    32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, LAT};
        vec[15] = '{F_REM,    32'd20,        32'hFFFFFFFD, 32'd2,        LAT};
        vec[16] = '{F_REM,    32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, LAT};
        vec[17] = '{F_MULHSU, 32'hFFFFFFFE,  32'd3,        32'hFFFFFFFF, LAT};
        vec[18] = '{F_REMU,   32'h12345678,  32'h100,      32'h78,       LAT};
        vec[19] = '{F_DIVU,   32'h80000000,  32'hFFFFFFFF, 32'h00000000, LAT};
        vec[20] = '{F_REMU,   32'h80000000,  32'hFFFFFFFF, 32'h80000000, LAT};
        vec[21] = '{F_DIV,    32'h80000000,  32'd1,        32'h80000000, LAT};
        vec[22] = '{F_MUL,    32'h12345678,  32'h10,       32'h23456780, LAT};
        vec[23] = '{F_DIVU,   32'd0,         32'd0,        32'hFFFFFFFF, 1};
        vec[24] = '{F_REMU,   32'd7,         32'd0,        32'd7,        1};

        rst_n    = 1'b0;
        flush_i  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        funct3_i = '0;
        rs1_i    = '0;
        rs2_i    = '0;
        #22;
        check("reset ready_o",  XLEN'(ready_o),  XLEN'(1));
        check("reset valid_o",  XLEN'(valid_o),  XLEN'(0));
        check("reset busy_o",   XLEN'(busy_o),   XLEN'(0));
        check("reset result_o", result_o,        '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_op(vec[i].f3, vec[i].a, vec[i].b, res, lat, bad);
            check($sformatf("vec%0d result", i),      res,          vec[i].exp);
            check($sformatf("vec%0d latency", i),     XLEN'(lat),   XLEN'(vec[i].lat));
            check($sformatf("vec%0d ready_low", i),   XLEN'(bad),   XLEN'(0));
            check($sformatf("vec%0d ready_after", i), XLEN'(ready_o), XLEN'(1));
        end

        // Backpressure: hold DONE while offering new requests
        funct3_i = F_DIVU;
        rs1_i    = 32'd100;
        rs2_i    = 32'd7;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        lat = 1;
        while (valid_o !== 1'b1 && lat < 4 * LAT) begin
            tick();
            lat++;
        end
        check("bp latency", XLEN'(lat), XLEN'(LAT));
        funct3_i = F_MUL;
        rs1_i    = 32'd3;
        rs2_i    = 32'd3;
        valid_i  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d result", k),  result_o,        32'd14);
            check($sformatf("bp%0d valid_o", k), XLEN'(valid_o),  XLEN'(1));
            check($sformatf("bp%0d ready_o", k), XLEN'(ready_o),  XLEN'(0));
            tick();
        end
        ready_i = 1'b1;
        tick();
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("bp release ready_o", XLEN'(ready_o), XLEN'(1));
        check("bp release valid_o", XLEN'(valid_o), XLEN'(0));
        check("bp release busy_o",  XLEN'(busy_o),  XLEN'(0));
        tick();
        check("bp no second accept", XLEN'(busy_o), XLEN'(0));
        check("bp result held",      result_o,      32'd14);

        // Reset asserted in CALC cycle 4
        funct3_i = F_MUL;
        rs1_i    = 32'd7;
        rs2_i    = 32'd9;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        tick();
        tick();
        check("pre-reset busy_o", XLEN'(busy_o), XLEN'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst ready_o",  XLEN'(ready_o), XLEN'(1));
        check("midrst valid_o",  XLEN'(valid_o), XLEN'(0));
        check("midrst busy_o",   XLEN'(busy_o),  XLEN'(0));
        check("midrst result_o", result_o,       '0);
        #2;
        rst_n = 1'b1;
        tick();
        check("postrst ready_o", XLEN'(ready_o), XLEN'(1));

        // Flush in CALC cycle 10
        funct3_i = F_MUL;
        rs1_i    = 32'h1234;
        rs2_i    = 32'h5678;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("preflush busy_o", XLEN'(busy_o), XLEN'(1));
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush ready_o", XLEN'(ready_o), XLEN'(1));
        check("flush valid_o", XLEN'(valid_o), XLEN'(0));
        check("flush busy_o",  XLEN'(busy_o),  XLEN'(0));
        seen = 0;
        for (int k = 0; k < LAT + 5; k++) begin
            if (valid_o === 1'b1) seen++;
            tick();
        end
        check("flush no valid_o", XLEN'(seen), XLEN'(0));
        run_op(F_MULHU, 32'd3, 32'd5, res, lat, bad);
        check("postflush MULHU result",  res,        32'd0);
        check("postflush MULHU latency", XLEN'(lat), XLEN'(LAT));

        // Flush in IDLE blocks acceptance
        funct3_i = F_DIVU;
        rs1_i    = 32'd5;
        rs2_i    = 32'd0;
        valid_i  = 1'b1;
        flush_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        flush_i = 1'b0;
        check("idle flush ready_o", XLEN'(ready_o), XLEN'(1));
        check("idle flush valid_o", XLEN'(valid_o), XLEN'(0));
        check("idle flush busy_o",  XLEN'(busy_o),  XLEN'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
